fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Controls the EX-stage operand muxes of the 5-stage pipeline; their select encoding is 00/01/10.
- Keeps a shadow copy of the register-use fields of the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Outputs per-cycle Forward A/B selects and the load-use stall.
- Counts inserted stall bubbles for performance visibility.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, stall-counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- id_valid_i  in  1  ID-stage instruction valid.
- id_rs1_i  in  REG_AW  ID source register 1.
- id_rs2_i  in  REG_AW  ID source register 2.
- id_use_rs1_i  in  1  ID instruction reads rs1.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- id_rd_i  in  REG_AW  ID destination register.
- id_regwrite_i  in  1  ID instruction writes rd.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  discard ID instruction (taken branch).
- freeze_i  in  1  global pipeline hold.
- forward_a_o  out  2  EX operand A select.
- forward_b_o  out  2  EX operand B select.
- stall_o  out  1  hold PC and IF/ID, insert bubble.
- stall_cnt_o  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Select encoding:
  - 00 = ID/EX register-file value.
  - 01 = MEM/WB write-back data.
  - 10 = EX/MEM ALU result.
  - 11 is never driven.
- Internal state, all cleared to 0 by rst_i (asynchronous assert, synchronous deassert handled by the reset source):
  - IDEX {v, rs1, rs2, use1, use2, rd, rw, mr}.
  - EXMEM {v, rd, rw, mr}.
  - MEMWB {v, rd, rw}.
  - stall counter.
- Reset values of outputs: forward_a_o=00, forward_b_o=00, stall_o=0, stall_cnt_o=0.
- Each rising edge with freeze_i=0:
  - MEMWB <= EXMEM fields (mr dropped).
  - EXMEM <= IDEX fields.
  - IDEX <= bubble (all zero) if stall_o or flush_i or !id_valid_i; otherwise the ID inputs.
- freeze_i=1: all state holds, stall counter holds; outputs are still computed from the held state.
- Forwarding, per operand X in {A,B}, with rsX/useX taken from IDEX:
  - Output is purely combinational from state registers; no input-to-output path.
  - Evaluated in order, first match wins.
  - 10 if IDEX.v & useX & EXMEM.v & EXMEM.rw & !EXMEM.mr & EXMEM.rd!=0 & EXMEM.rd==rsX.
  - else 01 if IDEX.v & useX & MEMWB.v & MEMWB.rw & MEMWB.rd!=0 & MEMWB.rd==rsX.
  - else 00.
- EX/MEM priority: EX/MEM beats MEM/WB when both match (youngest producer).
- Register x0: never forwarded.
- EX/MEM entry that is a load: never a forward source. The load-use stall guarantees this case does not arise; the bench asserts it.
- Load-use stall, combinational from inputs and IDEX:
  - stall_o = id_valid_i & !flush_i & IDEX.v & IDEX.mr & IDEX.rd!=0 & ((id_use_rs1_i & id_rs1_i==IDEX.rd) | (id_use_rs2_i & id_rs2_i==IDEX.rd)).
  - Exactly one bubble per load-use pair. On the next cycle the load sits in EXMEM and IDEX is a bubble, so stall_o falls.
- Simultaneous events:
  - flush_i with a load-use condition: flush wins, stall_o=0, no bubble counted, IDEX gets a bubble.
  - freeze_i with stall_o=1: stall_o stays asserted, counter does not increment.
- Stall counter: increments by 1 on each edge with stall_o=1 & freeze_i=0; saturates at all-ones and never wraps.
- Reset mid-operation: all shadow state and the counter clear immediately; outputs return to reset values within the same cycle.
- Scope: no write-back-to-ID bypass; the register file handles same-cycle write/read.

Test Plan:
- EX/MEM forward: `add x5,x1,x2` then `sub x6,x5,x3` -> when sub is in EX, forward_a_o=10, forward_b_o=00.
- MEM/WB forward and priority:
  - `add x5`; `nop`; `or x7,x5,x5` -> forward_a_o=01 and forward_b_o=01 for or in EX.
  - `add x5`; `add x5`; `and x8,x5,x0` -> forward_a_o=10 (EX/MEM wins), forward_b_o=00 (x0).
- Load-use:
  - `lw x4,0(x1)` then `add x9,x4,x2` -> stall_o=1 for exactly one cycle, stall_cnt_o 0->1.
  - Next cycle stall_o=0; add then in EX shows forward_a_o=01.
- Flush priority: load-use condition with flush_i=1 in the same cycle -> stall_o=0, stall_cnt_o unchanged, IDEX holds a bubble, so next cycle forward_a_o=00 and forward_b_o=00.
- Freeze and saturation:
  - freeze_i=1 for 3 cycles during a pending forward -> selects hold their values, no state advance.
  - Preload the counter near all-ones and run 3 load-use pairs -> stall_cnt_o stays 0xFFFF.
- Reset mid-run: assert rst_i asynchronously while forward_a_o=10 and stall_o=1 -> before the next clock edge, all outputs are 0; after release, the first instruction shows forward_a_o=00.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding and load-use hazard control for a 5-stage pipeline.
// Selects are combinational from shadow state; stall also looks at the ID inputs.
module fwd_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              flush_i,
   input  logic              freeze_i,
   output logic [1:0]        forward_a_o,
   output logic [1:0]        forward_b_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              use1;
      logic              use2;
      logic [REG_AW-1:0] rd;
      logic              rw;
      logic              mr;
   } idex_t;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              rw;
      logic              mr;
   } exmem_t;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              rw;
   } memwb_t;

   localparam logic [1:0]       SEL_RF  = 2'b00;
   localparam logic [1:0]       SEL_WB  = 2'b01;
   localparam logic [1:0]       SEL_EX  = 2'b10;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   idex_t            r_idex;
   exmem_t           r_exmem;
   memwb_t           r_memwb;
   logic [CNT_W-1:0] r_stall_cnt;

   idex_t            w_idex_nxt;
   logic             w_stall;
   logic             w_hit_rs1;
   logic             w_hit_rs2;

   // Youngest producer first; a load in EX/MEM has no data yet and x0 is hardwired.
   function automatic logic [1:0] fwd_sel(input logic              use_x,
                                          input logic [REG_AW-1:0] rs_x,
                                          input idex_t             idex,
                                          input exmem_t            exm,
                                          input memwb_t            mwb);
      logic [1:0] sel;
      sel = SEL_RF;
      if (idex.v && use_x && exm.v && exm.rw && !exm.mr &&
          (exm.rd != '0) && (exm.rd == rs_x))
         sel = SEL_EX;
      else if (idex.v && use_x && mwb.v && mwb.rw &&
               (mwb.rd != '0) && (mwb.rd == rs_x))
         sel = SEL_WB;
      return sel;
   endfunction

   always_comb begin
      forward_a_o = fwd_sel(r_idex.use1, r_idex.rs1, r_idex, r_exmem, r_memwb);
      forward_b_o = fwd_sel(r_idex.use2, r_idex.rs2, r_idex, r_exmem, r_memwb);
   end

   assign w_hit_rs1 = id_use_rs1_i && (id_rs1_i == r_idex.rd);
   assign w_hit_rs2 = id_use_rs2_i && (id_rs2_i == r_idex.rd);
   assign w_stall   = id_valid_i && !flush_i && r_idex.v && r_idex.mr &&
                      (r_idex.rd != '0) && (w_hit_rs1 || w_hit_rs2);

   assign stall_o     = w_stall;
   assign stall_cnt_o = r_stall_cnt;

   // A stalled or flushed ID instruction becomes a bubble; IF/ID re-presents it.
   always_comb begin
      w_idex_nxt = '0;
      if (id_valid_i && !flush_i && !w_stall) begin
         w_idex_nxt.v    = 1'b1;
         w_idex_nxt.rs1  = id_rs1_i;
         w_idex_nxt.rs2  = id_rs2_i;
         w_idex_nxt.use1 = id_use_rs1_i;
         w_idex_nxt.use2 = id_use_rs2_i;
         w_idex_nxt.rd   = id_rd_i;
         w_idex_nxt.rw   = id_regwrite_i;
         w_idex_nxt.mr   = id_memread_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_idex      <= '0;
         r_exmem     <= '0;
         r_memwb     <= '0;
         r_stall_cnt <= '0;
      end else if (!freeze_i) begin
         r_memwb.v   <= r_exmem.v;
         r_memwb.rd  <= r_exmem.rd;
         r_memwb.rw  <= r_exmem.rw;
         r_exmem.v   <= r_idex.v;
         r_exmem.rd  <= r_idex.rd;
         r_exmem.rw  <= r_idex.rw;
         r_exmem.mr  <= r_idex.mr;
         r_idex      <= w_idex_nxt;
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: stimulus pushes hand-computed expectations,
// a monitor pops and compares once per cycle (and on asynchronous reset).
module tb_fwd_hazard_ctrl;
   localparam int AW = 5;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          id_valid_i = 1'b0;
   logic [AW-1:0] id_rs1_i = '0;
   logic [AW-1:0] id_rs2_i = '0;
   logic          id_use_rs1_i = 1'b0;
   logic          id_use_rs2_i = 1'b0;
   logic [AW-1:0] id_rd_i = '0;
   logic          id_regwrite_i = 1'b0;
   logic          id_memread_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          freeze_i = 1'b0;

   logic [1:0]    fa, fb, fa_s, fb_s;
   logic          st, st_s;
   logic [15:0]   cnt;
   logic [1:0]    cnt_s;

   fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
      .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
      .flush_i(flush_i), .freeze_i(freeze_i),
      .forward_a_o(fa), .forward_b_o(fb), .stall_o(st), .stall_cnt_o(cnt)
   );

   // Narrow counter instance: saturation is reached within a few load-use pairs.
   fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(2)) dut_s (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
      .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
      .flush_i(flush_i), .freeze_i(freeze_i),
      .forward_a_o(fa_s), .forward_b_o(fb_s), .stall_o(st_s), .stall_cnt_o(cnt_s)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        st;
      logic [15:0] cnt;
      logic [1:0]  cnt_s;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   exp_cnt = 0;
   logic hazard;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, req, $time);
      end
   endtask

   always begin
      @(negedge clk_i or posedge rst_i);
      #1;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         chk("fwd_a", 16'(fa), 16'(mon_e.fa));
         chk("fwd_b", 16'(fb), 16'(mon_e.fb));
         chk("stall", 16'(st), 16'(mon_e.st));
         chk("stall_cnt", cnt, mon_e.cnt);
         chk("small_sel", 16'({fa_s, fb_s, st_s}), 16'({mon_e.fa, mon_e.fb, mon_e.st}));
         chk("stall_cnt_sat", 16'(cnt_s), 16'(mon_e.cnt_s));
      end
      if (!rst_i) begin
         hazard = dut.r_idex.v && dut.r_exmem.v && dut.r_exmem.mr && (dut.r_exmem.rd != '0) &&
                  ((dut.r_idex.use1 && (dut.r_idex.rs1 == dut.r_exmem.rd)) ||
                   (dut.r_idex.use2 && (dut.r_idex.rs2 == dut.r_exmem.rd)));
         chk("load_in_exmem_consumed", 16'(hazard), 16'd0);
      end
   end

   task automatic push_exp(input logic [1:0] efa, input logic [1:0] efb, input logic est);
      exp_t e;
      e.fa    = efa;
      e.fb    = efb;
      e.st    = est;
      e.cnt   = exp_cnt[15:0];
      e.cnt_s = (exp_cnt >= 3) ? 2'd3 : exp_cnt[1:0];
      q.push_back(e);
   endtask

   // One ID-stage instruction per cycle; rw is always set for real instructions.
   task automatic op(input int rs1, input int rs2, input logic u1, input logic u2,
                     input int rd, input logic mr, input logic fl, input logic fz,
                     input logic [1:0] efa, input logic [1:0] efb, input logic est);
      @(posedge clk_i);
      #1;
      id_valid_i    = 1'b1;
      id_rs1_i      = rs1[AW-1:0];
      id_rs2_i      = rs2[AW-1:0];
      id_use_rs1_i  = u1;
      id_use_rs2_i  = u2;
      id_rd_i       = rd[AW-1:0];
      id_regwrite_i = 1'b1;
      id_memread_i  = mr;
      flush_i       = fl;
      freeze_i      = fz;
      push_exp(efa, efb, est);
      if (est && !fz) exp_cnt++;
   endtask

   task automatic nop(input logic fz, input logic [1:0] efa, input logic [1:0] efb, input logic est);
      @(posedge clk_i);
      #1;
      id_valid_i    = 1'b0;
      id_rs1_i      = '0;
      id_rs2_i      = '0;
      id_use_rs1_i  = 1'b0;
      id_use_rs2_i  = 1'b0;
      id_rd_i       = '0;
      id_regwrite_i = 1'b0;
      id_memread_i  = 1'b0;
      flush_i       = 1'b0;
      freeze_i      = fz;
      push_exp(efa, efb, est);
      if (est && !fz) exp_cnt++;
   endtask

   initial begin
      push_exp(2'b00, 2'b00, 1'b0);
      #1 rst_i = 1'b1;
      #11 rst_i = 1'b0;

      // EX/MEM forward: add x5,x1,x2 ; sub x6,x5,x3
      op(1, 2, 1, 1, 5, 0, 0, 0, 2'b00, 2'b00, 0);
      op(5, 3, 1, 1, 6, 0, 0, 0, 2'b00, 2'b00, 0);
      nop(0, 2'b10, 2'b00, 0);
      // MEM/WB forward: add x5 ; nop ; or x7,x5,x5
      op(1, 2, 1, 1, 5, 0, 0, 0, 2'b00, 2'b00, 0);
      nop(0, 2'b00, 2'b00, 0);
      op(5, 5, 1, 1, 7, 0, 0, 0, 2'b00, 2'b00, 0);
      // Priority: add x5 ; add x5 ; and x8,x5,x0
      op(1, 2, 1, 1, 5, 0, 0, 0, 2'b01, 2'b01, 0);
      op(3, 4, 1, 1, 5, 0, 0, 0, 2'b00, 2'b00, 0);
      op(5, 0, 1, 1, 8, 0, 0, 0, 2'b00, 2'b00, 0);
      nop(0, 2'b10, 2'b00, 0);
      // x0 producer is never forwarded from either stage
      op(1, 2, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      op(0, 0, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 0);
      op(0, 0, 1, 1, 10, 0, 0, 0, 2'b00, 2'b00, 0);
      nop(0, 2'b00, 2'b00, 0);
      // Load-use on rs1: lw x4 ; add x9,x4,x2
      op(1, 0, 1, 0, 4, 1, 0, 0, 2'b00, 2'b00, 0);
      op(4, 2, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 1);
      op(4, 2, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 0);
      nop(0, 2'b01, 2'b00, 0);
      // Load-use on rs2
      op(1, 0, 1, 0, 4, 1, 0, 0, 2'b00, 2'b00, 0);
      op(2, 4, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 1);
      op(2, 4, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 0);
      nop(0, 2'b00, 2'b01, 0);
      // No stall: rs2 field matches but unused; load to x0
      op(1, 0, 1, 0, 4, 1, 0, 0, 2'b00, 2'b00, 0);
      op(2, 4, 1, 0, 9, 0, 0, 0, 2'b00, 2'b00, 0);
      op(1, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0);
      op(0, 0, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 0);
      nop(0, 2'b00, 2'b00, 0);
      // Flush beats load-use; flushed consumer would otherwise forward from MEM/WB
      op(1, 2, 1, 1, 5, 0, 0, 0, 2'b00, 2'b00, 0);
      op(1, 0, 1, 0, 4, 1, 0, 0, 2'b00, 2'b00, 0);
      op(4, 5, 1, 1, 9, 0, 1, 0, 2'b00, 2'b00, 0);
      nop(0, 2'b00, 2'b00, 0);
      // Freeze for 3 cycles with a pending EX/MEM forward
      op(1, 2, 1, 1, 5, 0, 0, 0, 2'b00, 2'b00, 0);
      op(5, 3, 1, 1, 6, 0, 0, 0, 2'b00, 2'b00, 0);
      nop(1, 2'b10, 2'b00, 0);
      op(5, 5, 1, 1, 7, 0, 0, 1, 2'b10, 2'b00, 0);
      op(5, 5, 1, 1, 7, 0, 0, 1, 2'b10, 2'b00, 0);
      nop(0, 2'b10, 2'b00, 0);
      nop(0, 2'b00, 2'b00, 0);
      // Freeze during a stall: held, not counted
      op(1, 0, 1, 0, 4, 1, 0, 0, 2'b00, 2'b00, 0);
      op(4, 2, 1, 1, 9, 0, 0, 1, 2'b00, 2'b00, 1);
      op(4, 2, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 1);
      op(4, 2, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 0);
      nop(0, 2'b01, 2'b00, 0);
      // Further pairs drive the narrow counter into saturation
      op(1, 0, 1, 0, 4, 1, 0, 0, 2'b00, 2'b00, 0);
      op(4, 2, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 1);
      op(4, 2, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 0);
      op(1, 0, 1, 0, 4, 1, 0, 0, 2'b01, 2'b00, 0);
      op(2, 4, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 1);
      op(2, 4, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 0);
      nop(0, 2'b00, 2'b01, 0);
      // Reset while forward_a=10 and stall=1
      op(1, 2, 1, 1, 5, 0, 0, 0, 2'b00, 2'b00, 0);
      op(5, 0, 1, 0, 4, 1, 0, 0, 2'b00, 2'b00, 0);
      op(4, 2, 1, 1, 9, 0, 0, 0, 2'b10, 2'b00, 1);
      @(negedge clk_i);
      #2;
      exp_cnt = 0;
      push_exp(2'b00, 2'b00, 1'b0);
      rst_i = 1'b1;
      @(posedge clk_i);
      #3;
      id_valid_i = 1'b0;
      id_use_rs1_i = 1'b0;
      id_use_rs2_i = 1'b0;
      id_memread_i = 1'b0;
      rst_i = 1'b0;
      op(5, 4, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00, 0);
      nop(0, 2'b00, 2'b00, 0);

      @(posedge clk_i);
      @(posedge clk_i);
      chk("scoreboard_drained", 16'(q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
